mem_port_arbiter: RTL

- Sequences and shares the 4x8-bit latch-based memory_system between two requesters, A and B.
- Each requester issues a read or write through a level req/done handshake.
- The arbiter grants round-robin and drives memory_system's data/store/addr inputs with a setup/strobe/hold write sequence, so the store strobe never overlaps an address or data change.
- It captures read data from memory_system's memory output and returns it to the granted requester.

---
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_port_arbiter.sv | 71 +++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the memory_system bus.
// The arbiter takes the slave side, the requesters and memory the master side.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              req_a, we_a, done_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              req_b, we_b, done_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_store;
  logic [DATA_W-1:0] mem_q;
  modport slave (
    input  req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, mem_q,
    output done_a, done_b, rdata, busy, mem_data, mem_addr, mem_store
  );
  modport master (
    output req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, mem_q,
    input  done_a, done_b, rdata, busy, mem_data, mem_addr, mem_store
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of a latch-based 4x8 memory between two requesters.
// Writes run setup/strobe/hold so the store strobe never overlaps an address or data change.
module mem_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, READ} state_t;
  state_t state_q, state_d;
  logic last_b_q, last_b_d, op_b_q, op_b_d;
  logic mem_store_q, mem_store_d, done_a_q, done_a_d, done_b_q, done_b_d, busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d, rdata_q, rdata_d;
  logic eff_a, eff_b, sel_b, sel_we, grant, finishing;
  always_comb begin
    // a requester whose done is showing is masked so a late req drop cannot re-grant it
    eff_a = bus.req_a & ~done_a_q;
    eff_b = bus.req_b & ~done_b_q;
    sel_b = eff_b & ~(eff_a & last_b_q);
    sel_we = sel_b ? bus.we_b : bus.we_a;
    grant = (state_q == IDLE) & (eff_a | eff_b);
    state_d = state_q == IDLE   ? (grant ? (sel_we ? SETUP : READ) : IDLE) :
              state_q == SETUP  ? STROBE :
              state_q == STROBE ? HOLD : IDLE;
    mem_addr_d = grant ? (sel_b ? bus.addr_b : bus.addr_a) : mem_addr_q;
    mem_data_d = grant ? (sel_b ? bus.wdata_b : bus.wdata_a) : mem_data_q;
    op_b_d = grant ? sel_b : op_b_q;
    last_b_d = grant ? sel_b : last_b_q;
    finishing = (state_q == HOLD) | (state_q == READ);
    done_a_d = finishing & ~op_b_q;
    done_b_d = finishing & op_b_q;
    rdata_d = state_q == READ ? bus.mem_q : rdata_q;
    mem_store_d = state_d == STROBE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_b_q <= 1'b1;
      op_b_q <= 1'b0;
      mem_store_q <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_b_q <= last_b_d;
      op_b_q <= op_b_d;
      mem_store_q <= mem_store_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      busy_q <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.mem_store = mem_store_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.done_a = done_a_q;
  assign bus.done_b = done_b_q;
  assign bus.busy = busy_q;
  assign bus.rdata = rdata_q;
endmodule
